// File: rtl/conffti_pkg.sv
// conffti_pkg: definitions shared across the conFFTi synth blocks.
//   note_en_t          - note event kind carried from the decoder to the voice allocator
//   MIDI status nibbles - upper nibble of channel-voice status bytes
//   midi_dec_state_t   - MIDI note decoder parser state
package conffti_pkg;

   typedef enum logic {
      OFF = 1'b0,
      ON  = 1'b1
   } note_en_t;

   localparam logic [3:0] NOTE_OFF      = 4'h8;
   localparam logic [3:0] NOTE_ON       = 4'h9;
   localparam logic [3:0] PROG_CHANGE   = 4'hC;
   localparam logic [3:0] CHAN_PRESSURE = 4'hD;

   // IDLE: no running status. WAIT_D1/WAIT_D2: expecting first/second data byte.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_D1 = 2'd1,
      WAIT_D2 = 2'd2
   } midi_dec_state_t;

endpackage

// File: rtl/midi_note_decoder.sv
// midi_note_decoder: parses a MIDI byte stream (with running status and transparent
// real-time bytes) into note on/off events for the voice allocator.
// Parameters:
//   CHANNEL    - MIDI channel accepted when OMNI=0
//   OMNI       - 1 accepts note messages on every channel
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-high reset
//   byte_valid - qualifies byte_in for one cycle
//   byte_in    - received MIDI byte
//   event_en   - one-cycle note event strobe (voice allocator input_en)
//   note_en    - ON/OFF for the event, held between events
//   note       - MIDI note number, held between events
//   velocity   - note velocity (0 for OFF), held between events
//   sync_error - one-cycle strobe when a data byte arrives with no running status
module midi_note_decoder
   import conffti_pkg::*;
#(
   parameter logic [3:0] CHANNEL = 4'd0,
   parameter bit         OMNI    = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       byte_valid,
   input  logic [7:0] byte_in,
   output logic       event_en,
   output note_en_t   note_en,
   output logic [6:0] note,
   output logic [6:0] velocity,
   output logic       sync_error
);

   midi_dec_state_t r_state, w_state;
   logic [7:0]      r_status, w_status;   // running status, 0 when none
   logic [6:0]      r_data1, w_data1;
   logic            r_event_en, w_event_en;
   logic            r_sync_error, w_sync_error;
   note_en_t        r_note_en, w_note_en;
   logic [6:0]      r_note, w_note;
   logic [6:0]      r_velocity, w_velocity;

   logic            w_complete;
   logic [6:0]      w_data2;
   logic            w_one_byte;
   logic            w_is_note;
   logic            w_chan_ok;

   assign w_one_byte = (r_status[7:4] == PROG_CHANGE) || (r_status[7:4] == CHAN_PRESSURE);
   assign w_is_note  = (r_status[7:4] == NOTE_ON) || (r_status[7:4] == NOTE_OFF);
   assign w_chan_ok  = OMNI || (r_status[3:0] == CHANNEL);

   always_comb begin
      w_state      = r_state;
      w_status     = r_status;
      w_data1      = r_data1;
      w_event_en   = 1'b0;
      w_sync_error = 1'b0;
      w_note_en    = r_note_en;
      w_note       = r_note;
      w_velocity   = r_velocity;
      w_complete   = 1'b0;
      w_data2      = '0;

      if (byte_valid) begin
         if (byte_in[7]) begin
            if (byte_in[7:3] == 5'b11111) begin
               // Real-time byte: transparent, even in the middle of a message.
            end else if (byte_in[7:4] == 4'hF) begin
               w_status = '0;
               w_state  = IDLE;
            end else begin
               w_status = byte_in;
               w_state  = WAIT_D1;
            end
         end else begin
            case (r_state)
               IDLE: w_sync_error = 1'b1;
               WAIT_D1: begin
                  w_data1 = byte_in[6:0];
                  if (w_one_byte) begin
                     w_complete = 1'b1;
                  end else begin
                     w_state = WAIT_D2;
                  end
               end
               WAIT_D2: begin
                  w_data2    = byte_in[6:0];
                  w_complete = 1'b1;
                  w_state    = WAIT_D1;
               end
               default: w_state = IDLE;
            endcase
         end
      end

      // One-byte messages are never note messages, so r_data1 is always the note here.
      if (w_complete && w_is_note && w_chan_ok) begin
         w_event_en = 1'b1;
         w_note     = r_data1;
         if ((r_status[7:4] == NOTE_ON) && (w_data2 != 7'd0)) begin
            w_note_en  = ON;
            w_velocity = w_data2;
         end else begin
            w_note_en  = OFF;
            w_velocity = 7'd0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_status     <= '0;
         r_data1      <= '0;
         r_event_en   <= 1'b0;
         r_sync_error <= 1'b0;
         r_note_en    <= OFF;
         r_note       <= '0;
         r_velocity   <= '0;
      end else begin
         r_state      <= w_state;
         r_status     <= w_status;
         r_data1      <= w_data1;
         r_event_en   <= w_event_en;
         r_sync_error <= w_sync_error;
         r_note_en    <= w_note_en;
         r_note       <= w_note;
         r_velocity   <= w_velocity;
      end
   end

   assign event_en   = r_event_en;
   assign sync_error = r_sync_error;
   assign note_en    = r_note_en;
   assign note       = r_note;
   assign velocity   = r_velocity;

endmodule

// File: tb/tb_midi_note_decoder.sv
// tb_midi_note_decoder: directed and randomized check of midi_note_decoder.
// Two instances share one byte stream: u_dut0 (channel 0, filtered) and
// u_dut1 (channel 3, omni). A message-level reference model predicts both.
module tb_midi_note_decoder;
   import conffti_pkg::*;

   localparam int CH0 = 0;
   localparam bit OM0 = 1'b0;
   localparam int CH1 = 3;
   localparam bit OM1 = 1'b1;

   logic       clk = 1'b0;
   logic       reset;
   logic       byte_valid;
   logic [7:0] byte_in;

   logic       ev0, se0, ev1, se1;
   note_en_t   ne0, ne1;
   logic [6:0] note0, vel0, note1, vel1;

   int tests_run = 0;
   int tests_failed = 0;
   int ev_cnt0 = 0;
   int ev_cnt1 = 0;
   int se_cnt = 0;

   // Reference model: running status plus the data bytes collected so far.
   int         m_status;
   logic [6:0] m_pend[$];
   logic       exp_ev[2];
   logic       exp_se;
   logic       exp_on[2];
   logic [6:0] exp_note[2];
   logic [6:0] exp_vel[2];

   always #5 clk = ~clk;

   midi_note_decoder #(.CHANNEL(4'(CH0)), .OMNI(OM0)) u_dut0 (
      .clk        (clk),
      .reset      (reset),
      .byte_valid (byte_valid),
      .byte_in    (byte_in),
      .event_en   (ev0),
      .note_en    (ne0),
      .note       (note0),
      .velocity   (vel0),
      .sync_error (se0)
   );

   midi_note_decoder #(.CHANNEL(4'(CH1)), .OMNI(OM1)) u_dut1 (
      .clk        (clk),
      .reset      (reset),
      .byte_valid (byte_valid),
      .byte_in    (byte_in),
      .event_en   (ev1),
      .note_en    (ne1),
      .note       (note1),
      .velocity   (vel1),
      .sync_error (se1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_status = -1;
      m_pend.delete();
      exp_se = 1'b0;
      for (int k = 0; k < 2; k++) begin
         exp_ev[k]   = 1'b0;
         exp_on[k]   = 1'b0;
         exp_note[k] = '0;
         exp_vel[k]  = '0;
      end
   endtask

   task automatic model_byte(input logic v, input logic [7:0] b);
      int need;
      int hi;
      int ch;
      bit ok;
      exp_se = 1'b0;
      exp_ev[0] = 1'b0;
      exp_ev[1] = 1'b0;
      if (!v) return;
      if (b >= 8'hF8) return;
      if (b >= 8'hF0) begin
         m_status = -1;
         m_pend.delete();
      end else if (b >= 8'h80) begin
         m_status = int'(b);
         m_pend.delete();
      end else if (m_status < 0) begin
         exp_se = 1'b1;
      end else begin
         m_pend.push_back(b[6:0]);
         need = (m_status >= 8'hC0 && m_status <= 8'hDF) ? 1 : 2;
         if (m_pend.size() == need) begin
            hi = m_status / 16;
            ch = m_status % 16;
            if (hi == 8 || hi == 9) begin
               for (int k = 0; k < 2; k++) begin
                  ok = (k == 0) ? (OM0 || ch == CH0) : (OM1 || ch == CH1);
                  if (ok) begin
                     exp_ev[k]   = 1'b1;
                     exp_on[k]   = (hi == 9) && (m_pend[1] != 0);
                     exp_note[k] = m_pend[0];
                     exp_vel[k]  = exp_on[k] ? m_pend[1] : 7'd0;
                  end
               end
            end
            m_pend.delete();
         end
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".ev0"}, ev0, exp_ev[0]);
      check({tag, ".se0"}, se0, exp_se);
      check({tag, ".on0"}, ne0, exp_on[0]);
      check({tag, ".note0"}, note0, exp_note[0]);
      check({tag, ".vel0"}, vel0, exp_vel[0]);
      check({tag, ".ev1"}, ev1, exp_ev[1]);
      check({tag, ".se1"}, se1, exp_se);
      check({tag, ".on1"}, ne1, exp_on[1]);
      check({tag, ".note1"}, note1, exp_note[1]);
      check({tag, ".vel1"}, vel1, exp_vel[1]);
   endtask

   // Called #1 after a rising edge; drives one cycle, checks the registered result.
   task automatic step(input logic v, input logic [7:0] b, input string tag);
      byte_valid = v;
      byte_in    = b;
      model_byte(v, b);
      @(posedge clk);
      #1;
      compare_all(tag);
      if (ev0 === 1'b1) ev_cnt0++;
      if (ev1 === 1'b1) ev_cnt1++;
      if (se0 === 1'b1) se_cnt++;
      byte_valid = 1'b0;
   endtask

   task automatic do_reset();
      byte_valid = 1'b0;
      reset = 1'b1;
      model_reset();
      #2;
      compare_all("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic send(input logic [7:0] bytes[$], input string tag);
      foreach (bytes[i]) step(1'b1, bytes[i], tag);
      step(1'b0, 8'h00, tag);
   endtask

   function automatic logic [7:0] rand_byte();
      int r;
      int c;
      r = $urandom_range(99);
      c = $urandom_range(2);
      c = (c == 0) ? CH0 : (c == 1) ? CH1 : $urandom_range(15);
      if (r < 8) return 8'h00;
      if (r < 50) return 8'($urandom_range(127));
      if (r < 60) return 8'(8'h90 | c);
      if (r < 67) return 8'(8'h80 | c);
      if (r < 73) return 8'($urandom_range(8'hEF, 8'hA0));
      if (r < 80) return 8'($urandom_range(8'hFF, 8'hF8));
      if (r < 83) return 8'($urandom_range(8'hF7, 8'hF0));
      return 8'($urandom_range(127));
   endfunction

   initial begin
      int e0, e1, s0;
      reset      = 1'b1;
      byte_valid = 1'b0;
      byte_in    = 8'h00;
      do_reset();

      // Note on with one-cycle latency.
      e0 = ev_cnt0;
      step(1'b1, 8'h90, "t34");
      step(1'b1, 8'h3C, "t34");
      step(1'b1, 8'h64, "t34");
      check("t34_ev", ev0, 1'b1);
      check("t34_on", ne0, ON);
      check("t34_note", note0, 7'd60);
      check("t34_vel", vel0, 7'd100);
      step(1'b0, 8'h00, "t34");
      check("t34_hold_note", note0, 7'd60);
      check("t34_count", ev_cnt0 - e0, 1);

      // Running-status velocity-0 off, then explicit note off.
      e0 = ev_cnt0;
      send('{8'h3C, 8'h00, 8'h80, 8'h3C, 8'h40}, "t35");
      check("t35_count", ev_cnt0 - e0, 2);
      check("t35_off", ne0, OFF);
      check("t35_vel", vel0, 7'd0);

      // Channel filter.
      e0 = ev_cnt0;
      e1 = ev_cnt1;
      send('{8'h91, 8'h3C, 8'h64, 8'h3E, 8'h50}, "t36");
      check("t36_filtered", ev_cnt0 - e0, 0);
      check("t36_omni_count", ev_cnt1 - e1, 2);
      check("t36_omni_note", note1, 7'd62);
      check("t36_omni_vel", vel1, 7'd80);

      // Real-time bytes mid-message; one-byte program changes.
      e0 = ev_cnt0;
      send('{8'h90, 8'h3C, 8'hF8, 8'hFE, 8'h64}, "t37a");
      check("t37_rt_count", ev_cnt0 - e0, 1);
      check("t37_rt_vel", vel0, 7'd100);
      e0 = ev_cnt0;
      s0 = se_cnt;
      send('{8'hC0, 8'h05, 8'h07}, "t37b");
      check("t37_pc_ev", ev_cnt0 - e0, 0);
      check("t37_pc_se", se_cnt - s0, 0);

      // Data after reset is a sync error; reset aborts a partial message.
      do_reset();
      e0 = ev_cnt0;
      s0 = se_cnt;
      send('{8'h3C}, "t38a");
      step(1'b1, 8'h90, "t38b");
      step(1'b1, 8'h3C, "t38b");
      do_reset();
      send('{8'h64}, "t38b");
      check("t38_se", se_cnt - s0, 2);
      check("t38_ev", ev_cnt0 - e0, 0);

      // Randomized stream with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(199) == 0) begin
            do_reset();
         end else begin
            step(($urandom_range(99) < 85) ? 1'b1 : 1'b0, rand_byte(), "rand");
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
